// File: rtl/sreg_pkg.sv
// ---------------------------------------------------------------------------
// sreg_pkg
// Shared constants and the controller state type for the pixel shift
// register master. SREG_W is the default register length (must be even);
// SREG_HALF is the spacing between the two readout taps; SREG_CNT_W sizes
// the bit counter so it can reach SREG_W-2.
// ---------------------------------------------------------------------------
package sreg_pkg;

    localparam int SREG_W     = 42;
    localparam int SREG_HALF  = SREG_W / 2;
    localparam int SREG_CNT_W = $clog2(SREG_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        READ      = 3'd2,
        CFG_SHIFT = 3'd3,
        CFG_WRITE = 3'd4
    } state_t;

endpackage

// File: rtl/sreg_pix_buf.sv
// ---------------------------------------------------------------------------
// sreg_pix_buf
// Single-entry valid/ready holding register for the reassembled pixel word.
// Ports:
//   sclk, rst_n  clock and synchronous active-low reset
//   i_load       capture i_data and raise o_valid (only issued while empty)
//   i_data       reassembled pixel word
//   i_ready      consumer accepts the held word
//   o_valid      a word is held
//   o_data       the held word, stable while o_valid is high
// ---------------------------------------------------------------------------
module sreg_pix_buf
    import sreg_pkg::*;
#(
    parameter int W = SREG_W
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // The controller never loads while a word is held, so a load and a pop
    // cannot collide; a pop with nothing held simply leaves the entry empty.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/sreg_ctrl.sv
// ---------------------------------------------------------------------------
// sreg_ctrl
// Controller-side master for the pixel shift register. Serializes a config
// word MSB first and commits it with one write_cfg strobe, and reads the
// pixel word back in parallel over the two taps, reassembling it into a
// single-entry output buffer.
// Ports:
//   sclk, rst_n              shared clock, synchronous active-low reset
//   cfg_valid/cfg_ready      config handshake, cfg_data is the word
//   rd_req                   level request for one pixel readout
//   busy                     controller not in IDLE
//   pix_valid/pix_ready      output handshake, pix_data is the word
//   shift, serial_in         register shift enable and serial data
//   write_cfg                register config commit strobe
//   sreg_out                 taps: [1] = bit W-1, [0] = bit HALF-1
// Requires W even and at least 4.
// ---------------------------------------------------------------------------
module sreg_ctrl
    import sreg_pkg::*;
#(
    parameter int W = SREG_W
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [W-1:0] cfg_data,
    input  logic         rd_req,
    output logic         busy,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic [W-1:0] pix_data,
    output logic         shift,
    output logic         serial_in,
    output logic         write_cfg,
    input  logic [1:0]   sreg_out
);

    localparam int HALF = W / 2;
    localparam int CW   = $clog2(W);
    localparam logic [CW-1:0] CNT_CFG_LAST = CW'(W - 2);
    localparam logic [CW-1:0] CNT_RD_LAST  = CW'(HALF - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_cfg_buf;
    logic [HALF-2:0] r_hi;
    logic [HALF-2:0] r_lo;
    logic            w_cfg_accept;
    logic            w_rd_accept;
    logic            w_rd_done;
    logic            w_pix_valid;
    logic [W-1:0]    w_pix_word;

    assign cfg_ready    = (r_state == IDLE) && rst_n;
    assign w_cfg_accept = cfg_valid && cfg_ready;
    assign w_rd_accept  = (r_state == IDLE) && rd_req && !w_pix_valid;
    assign w_rd_done    = (r_state == READ) && (r_cnt == CNT_RD_LAST);

    // Next-state decode. Config wins over a readout request in IDLE; a held
    // rd_req is picked up on the IDLE cycle after the config commits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_cfg_accept) begin
                    w_state_next = CFG_SHIFT;
                end else if (w_rd_accept) begin
                    w_state_next = LOAD;
                end
            end
            LOAD:      w_state_next = READ;
            READ:      if (r_cnt == CNT_RD_LAST)  w_state_next = IDLE;
            CFG_SHIFT: if (r_cnt == CNT_CFG_LAST) w_state_next = CFG_WRITE;
            CFG_WRITE: w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // State and bit counter. The counter restarts on every state entry and
    // only advances in the two multi-cycle states.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != r_state) ||
                !((r_state == READ) || (r_state == CFG_SHIFT))) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Config shifter: the MSB always drives serial_in, so shifting left once
    // per CFG_SHIFT cycle leaves cfg[0] at the top for the CFG_WRITE cycle.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_cfg_buf <= '0;
        end else if (w_cfg_accept) begin
            r_cfg_buf <= cfg_data;
        end else if (r_state == CFG_SHIFT) begin
            r_cfg_buf <= {r_cfg_buf[W-2:0], 1'b0};
        end
    end

    // Deserializer: each READ edge samples both taps before the register
    // shifts. The earliest sample ends up at the top of each half, and the
    // final edge's samples are merged straight into the buffered word.
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == READ) begin
            r_hi <= (r_hi << 1) | (HALF-1)'(sreg_out[1]);
            r_lo <= (r_lo << 1) | (HALF-1)'(sreg_out[0]);
        end
    end

    assign w_pix_word = {r_hi, sreg_out[1], r_lo, sreg_out[0]};

    sreg_pix_buf #(.W(W)) u_pix_buf (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .i_load  (w_rd_done),
        .i_data  (w_pix_word),
        .i_ready (pix_ready),
        .o_valid (w_pix_valid),
        .o_data  (pix_data)
    );

    assign pix_valid = w_pix_valid;
    assign busy      = (r_state != IDLE);
    assign shift     = (r_state == READ) || (r_state == CFG_SHIFT);
    assign write_cfg = (r_state == CFG_WRITE);
    assign serial_in = ((r_state == CFG_SHIFT) || (r_state == CFG_WRITE)) && r_cfg_buf[W-1];

endmodule

// File: tb/tb_sreg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sreg_ctrl
// Bench for sreg_ctrl with a behavioural model of the 42-bit pixel shift
// register as its peer. Stimulus pushes expected pixel words and config
// words into queues; separate monitors pop and compare when the DUT
// presents a pixel word or commits a config word.
// ---------------------------------------------------------------------------
module tb_sreg_ctrl;

    localparam int W    = 42;
    localparam int HALF = W / 2;

    logic         sclk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_data;
    logic         rd_req;
    logic         busy;
    logic         pix_valid;
    logic         pix_ready;
    logic [W-1:0] pix_data;
    logic         shift;
    logic         serial_in;
    logic         write_cfg;
    logic [1:0]   sreg_out;

    logic [W-1:0] pixelIn;
    logic [W-1:0] sregModel;
    logic [W-1:0] cfgOut;
    logic         cfgWriteSeen;
    logic         validPrev;
    int           cycle;
    int           checks;
    int           errors;

    logic [W-1:0] pixExpQ[$];
    int           pixCycQ[$];
    logic [W-1:0] cfgExpQ[$];
    int           cfgCycQ[$];

    sreg_ctrl #(.W(W)) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .rd_req    (rd_req),
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .shift     (shift),
        .serial_in (serial_in),
        .write_cfg (write_cfg),
        .sreg_out  (sreg_out)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Edge counter: at a negedge, cycle holds the index of the last posedge.
    initial cycle = 0;
    always @(posedge sclk) cycle <= cycle + 1;

    // Pixel shift register peer: shifts or parallel-loads every edge and
    // commits {sreg[W-2:0], serial_in} to its config output on write_cfg.
    initial begin
        sregModel    = '0;
        cfgOut       = '0;
        cfgWriteSeen = 1'b0;
    end
    always @(posedge sclk) begin
        if (write_cfg) cfgOut <= {sregModel[W-2:0], serial_in};
        if (shift) sregModel <= {sregModel[W-2:0], serial_in};
        else       sregModel <= pixelIn;
        cfgWriteSeen <= write_cfg;
    end
    assign sreg_out = {sregModel[W-1], sregModel[HALF-1]};

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Pixel monitor: compares each newly presented word and its edge.
    initial validPrev = 1'b0;
    always @(negedge sclk) begin
        if (pix_valid && !validPrev) begin
            if (pixExpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pix_unexpected actual=%0h expected=none", pix_data);
            end else begin
                checkOutput("pix_data", 64'(pix_data), 64'(pixExpQ.pop_front()));
                checkOutput("pix_latency", 64'(cycle), 64'(pixCycQ.pop_front()));
            end
        end
        validPrev = pix_valid;
    end

    // Config monitor: after each write_cfg edge, compares the register's
    // committed word and the edge it happened on.
    always @(negedge sclk) begin
        if (cfgWriteSeen) begin
            if (cfgExpQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL cfg_unexpected actual=%0h expected=none", cfgOut);
            end else begin
                checkOutput("cfg_out", 64'(cfgOut), 64'(cfgExpQ.pop_front()));
                checkOutput("cfg_write_edge", 64'(cycle), 64'(cfgCycQ.pop_front()));
            end
        end
    end

    task automatic waitDrain(input string name, input int bound);
        int k = 0;
        while ((pixExpQ.size() != 0 || cfgExpQ.size() != 0 || busy) && k < bound) begin
            @(negedge sclk);
            k++;
        end
        if (k >= bound) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=%0d expected<%0d", name, k, bound);
        end
        @(negedge sclk);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_shift"},     64'(shift),     64'd0);
        checkOutput({name, "_serial_in"}, 64'(serial_in), 64'd0);
        checkOutput({name, "_write_cfg"}, 64'(write_cfg), 64'd0);
        checkOutput({name, "_busy"},      64'(busy),      64'd0);
        checkOutput({name, "_pix_valid"}, 64'(pix_valid), 64'd0);
        checkOutput({name, "_pix_data"},  64'(pix_data),  64'd0);
        checkOutput({name, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
    endtask

    // Full config write; the monitor checks the committed word and edge.
    task automatic applyConfig(input logic [W-1:0] data);
        int shiftCnt = 0;
        int writeCnt = 0;
        @(negedge sclk);
        cfg_data  = data;
        cfg_valid = 1'b1;
        cfgExpQ.push_back(data);
        cfgCycQ.push_back(cycle + 1 + W);
        @(negedge sclk);
        cfg_valid = 1'b0;
        for (int k = 0; k < W + 2; k++) begin
            if (shift)     shiftCnt++;
            if (write_cfg) writeCnt++;
            @(negedge sclk);
        end
        checkOutput("cfg_shift_cycles", 64'(shiftCnt), 64'(W - 1));
        checkOutput("cfg_write_cycles", 64'(writeCnt), 64'd1);
        checkOutput("cfg_ready_after",  64'(cfg_ready), 64'd1);
        waitDrain("cfg", 20);
    endtask

    // One pulsed readout; optionally scrambles pixel_in after the LOAD edge.
    task automatic applyStimulus(input logic [W-1:0] data, input bit wiggle);
        @(negedge sclk);
        pixelIn = data;
        rd_req  = 1'b1;
        pixExpQ.push_back(data);
        pixCycQ.push_back(cycle + 1 + HALF + 1);
        @(negedge sclk);
        rd_req = 1'b0;
        @(negedge sclk);
        if (wiggle) begin
            for (int k = 0; k < HALF + 2; k++) begin
                pixelIn = W'({$urandom(), $urandom()});
                @(negedge sclk);
            end
        end
        waitDrain("readout", 60);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int busyHigh;
        int wc;
        int target;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        rd_req    = 1'b0;
        pix_ready = 1'b1;
        pixelIn   = '0;

        repeat (3) @(negedge sclk);
        checkAllZero("reset");
        rst_n = 1'b1;
        @(negedge sclk);
        checkOutput("idle_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("idle_busy",      64'(busy),      64'd0);

        $display("[TB] config write");
        applyConfig(42'h2A5C3F00F15);

        $display("[TB] readouts");
        applyStimulus(42'h3FF00000001, 1'b0);
        applyStimulus(42'h3FFFFFFFFFF, 1'b0);
        applyStimulus(42'h00000000000, 1'b0);
        applyStimulus(42'h2AAAAAAAAAA, 1'b0);
        applyStimulus(42'h1234567ABCD, 1'b1);

        $display("[TB] backpressure");
        pix_ready = 1'b0;
        @(negedge sclk);
        pixelIn = 42'h0F0F0F0F0F0;
        rd_req  = 1'b1;
        pixExpQ.push_back(42'h0F0F0F0F0F0);
        pixCycQ.push_back(cycle + 1 + HALF + 1);
        repeat (HALF + 4) @(negedge sclk);
        busyHigh = 0;
        repeat (8) begin
            @(negedge sclk);
            if (busy) busyHigh++;
        end
        checkOutput("bp_single_readout", 64'(busyHigh),  64'd0);
        checkOutput("bp_valid_held",     64'(pix_valid), 64'd1);
        checkOutput("bp_data_held",      64'(pix_data),  64'h0F0F0F0F0F0);
        pixelIn   = 42'h30C30C30C30;
        pix_ready = 1'b1;
        @(negedge sclk);
        pix_ready = 1'b0;
        checkOutput("bp_popped", 64'(pix_valid), 64'd0);
        pixExpQ.push_back(42'h30C30C30C30);
        pixCycQ.push_back(cycle + 1 + HALF + 1);
        @(negedge sclk);
        rd_req = 1'b0;
        checkOutput("bp_second_start", 64'(busy), 64'd1);
        repeat (HALF + 4) @(negedge sclk);
        pix_ready = 1'b1;
        waitDrain("backpressure", 60);

        $display("[TB] config and readout together");
        @(negedge sclk);
        cfg_data  = 42'h12345678ABC;
        cfg_valid = 1'b1;
        rd_req    = 1'b1;
        pixelIn   = 42'h2F0E1D2C3B4;
        cfgExpQ.push_back(42'h12345678ABC);
        cfgCycQ.push_back(cycle + 1 + W);
        pixExpQ.push_back(42'h2F0E1D2C3B4);
        pixCycQ.push_back(cycle + 1 + W + 1 + HALF + 1);
        target = cycle + 1 + W + 1;
        @(negedge sclk);
        cfg_valid = 1'b0;
        for (int k = 0; k < W + 10 && cycle < target; k++) @(negedge sclk);
        rd_req = 1'b0;
        checkOutput("both_read_started", 64'(busy), 64'd1);
        waitDrain("both", 80);

        $display("[TB] reset during config shift");
        wc = 0;
        @(negedge sclk);
        cfg_data  = 42'h3C3C3C3C3C3;
        cfg_valid = 1'b1;
        @(negedge sclk);
        cfg_valid = 1'b0;
        repeat (20) begin
            if (write_cfg) wc++;
            @(negedge sclk);
        end
        rst_n = 1'b0;
        @(negedge sclk);
        checkAllZero("midreset");
        rst_n = 1'b1;
        repeat (W + 4) begin
            @(negedge sclk);
            if (write_cfg) wc++;
        end
        checkOutput("midreset_no_write", 64'(wc),        64'd0);
        checkOutput("midreset_cfg_kept", 64'(cfgOut),    64'h12345678ABC);
        checkOutput("midreset_ready",    64'(cfg_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
